fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and decode. Decouples the two stages.
- Stores fetched if_id_data_t packets (instr, pc, pc_plus_4) in a small circular FIFO.
- Presents the oldest packet to decode with a valid/ready handshake.
- Back-pressures fetch through stall_f_o; drops all queued wrong-path instructions when Execute redirects the PC.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- NOP_INSTR, 32'h0000_0013, instruction word driven on instr_o when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- fetch_valid_i  input  1  fetch presents a valid packet this cycle
- fetch_data_i  input  if_id_data_t  packet from fetch (instr, pc, pc_plus_4, each 32 bits)
- stall_f_o  output  1  queue full; fetch must hold its PC
- flush_i  input  1  branch/jump redirect from Execute (pc_src_e); discard contents
- dec_valid_o  output  1  head entry valid
- dec_ready_i  input  1  decode accepts head entry this cycle
- dec_data_o  output  if_id_data_t  head entry
- count_o  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - dec_valid_o=0, stall_f_o=0, count_o=0.
  - dec_data_o = {NOP_INSTR, 32'h0, 32'h0}.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards everything immediately. The first push is accepted on the first posedge after rst deasserts.
- push = fetch_valid_i && !full && !flush_i.
- pop = dec_valid_o && dec_ready_i && !flush_i.
- full = (count == DEPTH); empty = (count == 0).
- stall_f_o = full. It is a registered-state function with no combinational path from dec_ready_i.
- When full, the queue does not accept a push even if a pop occurs that cycle. This is a conservative rule that keeps stall off the decode timing path.
- Push: write fetch_data_i at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop: advance rd_ptr; rd_ptr wraps modulo DEPTH.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Push while empty: the packet appears on dec_data_o with dec_valid_o=1 in the next cycle. There is no same-cycle bypass, so minimum latency is 1 cycle.
- Output is show-ahead: dec_data_o = mem[rd_ptr] whenever count>0, and is stable until popped. dec_valid_o = !empty.
- Empty: dec_valid_o=0; dec_data_o.instr=NOP_INSTR, pc=0, pc_plus_4=0.
- Flush (highest priority after reset):
  - On the posedge with flush_i=1, set count=0, rd_ptr=wr_ptr=0.
  - The same-cycle fetch packet is discarded as wrong-path, and the same-cycle pop is not counted.
  - Next cycle: dec_valid_o=0, stall_f_o=0.
  - A flush while empty is harmless.
  - Back-to-back flushes keep the queue empty.
- Pushes with fetch_valid_i=0 are ignored. A pop with dec_ready_i=1 while empty is ignored.
- count never exceeds DEPTH and never underflows.
- Assertions:
  - Bench checks that no push occurs when full.
  - dec_data_o stays stable while dec_valid_o && !dec_ready_i && !flush_i.

Decomposition:
- if_id_data_t stays in the shared pipeline types header.
- Add a NOP_INSTR constant to the shared defines header; the parameter default references it.
- Pointer and count widths derive locally from DEPTH.
- No sub-module: storage, pointers and counter live in one module.
- The pipeline top instantiates fetch_queue in place of the plain IF/ID register. pc_src_e drives flush_i; stall_f_o ORs into fetch's stall input.

Test Plan:
- Reset/empty: hold rst=1 then release. Expect dec_valid_o=0, instr=32'h13, stall_f_o=0, count_o=0.
- Fill: fetch_valid_i=1 with pc 0x0,0x4,0x8,0xC, dec_ready_i=0.
  - stall_f_o=1 after the 4th push, count_o=4.
  - A 5th packet (pc 0x10) is not stored.
  - Release dec_ready_i: pops in order 0x0,0x4,0x8,0xC. Then dec_valid_o=0.
- Streaming: dec_ready_i=1 constant, 10 sequential packets. Each emerges 1 cycle after push, count_o stays 1, pointers wrap past DEPTH with order preserved.
- Full with simultaneous pop: full queue, dec_ready_i=1, fetch_valid_i=1.
  - Pop occurs, push refused.
  - Next cycle count_o=3, stall_f_o=0.
  - The following push is accepted.
- Flush: queue holding pc 0x20,0x24,0x28; assert flush_i with fetch_valid_i=1 (pc 0x2C) and dec_ready_i=1.
  - Next cycle count_o=0, dec_valid_o=0; 0x2C absent.
  - A push of target pc 0x100 appears next with pc_plus_4=0x104.
- Async reset mid-stream: assert rst between clock edges while count_o=2. Outputs go to reset values immediately, before the next edge.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared IF/ID pipeline types and constants used by the fetch/decode boundary.
package fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
    } if_id_data_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode with show-ahead output,
// full-based fetch back-pressure and redirect flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_valid_i,
    input  if_id_data_t            fetch_data_i,
    output logic                   stall_f_o,
    input  logic                   flush_i,
    output logic                   dec_valid_o,
    input  logic                   dec_ready_i,
    output if_id_data_t            dec_data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    if_id_data_t         mem [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                full, empty, push, pop;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);

    // Full blocks pushes even when a pop frees a slot, so stall never depends on dec_ready_i.
    assign push = fetch_valid_i && !full && !flush_i;
    assign pop  = !empty && dec_ready_i && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_d = count_q + CntW'(1);
            else if (pop && !push) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= fetch_data_i;
    end

    always_comb begin
        if (empty) begin
            dec_data_o.instr     = NOP_INSTR;
            dec_data_o.pc        = '0;
            dec_data_o.pc_plus_4 = '0;
        end else begin
            dec_data_o = mem[rd_ptr_q];
        end
    end

    assign dec_valid_o = !empty;
    assign stall_f_o   = full;
    assign count_o     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    if_id_data_t fetch_data;
    logic        stall_f;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    if_id_data_t dec_data;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid_i(fetch_valid),
        .fetch_data_i (fetch_data),
        .stall_f_o    (stall_f),
        .flush_i      (flush),
        .dec_valid_o  (dec_valid),
        .dec_ready_i  (dec_ready),
        .dec_data_o   (dec_data),
        .count_o      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc);
        fetch_valid          = v;
        fetch_data.instr     = 32'hA000_0000 | pc;
        fetch_data.pc        = pc;
        fetch_data.pc_plus_4 = pc + 32'd4;
    endtask

    // Head must hold while stalled by decode; a full queue must never grow.
    always @(posedge clk) begin
        logic        hold, was_full;
        if_id_data_t prev;
        logic [2:0]  prev_count;
        hold       = dec_valid && !dec_ready && !flush && !rst;
        was_full   = stall_f && !rst;
        prev       = dec_data;
        prev_count = count;
        #1;
        if (hold && !rst) check("head_stable", dec_data.pc, prev.pc);
        if (was_full && !rst) begin
            checks++;
            assert (count <= prev_count) else begin
                failures++;
                $error("FAIL push_when_full observed=%0d expected<=%0d", count, prev_count);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; dec_ready = 1'b0;
        drive(1'b0, 32'h0);
        step(); step();
        rst = 1'b0;
        check("rst_valid", 32'(dec_valid), 32'd0);
        check("rst_instr", dec_data.instr, 32'h13);
        check("rst_pc",    dec_data.pc, 32'h0);
        check("rst_stall", 32'(stall_f), 32'd0);
        check("rst_count", 32'(count), 32'd0);

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i));
            step();
            check("fill_valid", 32'(dec_valid), 32'd1);
            check("fill_head",  dec_data.pc, 32'h0);
        end
        check("fill_stall", 32'(stall_f), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        drive(1'b1, 32'h10);
        step();
        check("fifth_count", 32'(count), 32'd4);
        check("fifth_head",  dec_data.pc, 32'h0);
        drive(1'b0, 32'h0);
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc",  dec_data.pc, 32'(4 * i));
            check("drain_p4",  dec_data.pc_plus_4, 32'(4 * i + 4));
            step();
        end
        check("drain_valid", 32'(dec_valid), 32'd0);
        check("drain_instr", dec_data.instr, 32'h13);
        check("drain_count", 32'(count), 32'd0);

        // Pop while empty is ignored
        step();
        check("empty_pop_count", 32'(count), 32'd0);

        // Streaming: each packet emerges one cycle after push
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * i));
            step();
            check("stream_valid", 32'(dec_valid), 32'd1);
            check("stream_pc",    dec_data.pc, 32'h40 + 32'(4 * i));
            check("stream_instr", dec_data.instr, 32'hA000_0040 + 32'(4 * i));
            check("stream_count", 32'(count), 32'd1);
        end
        drive(1'b0, 32'h0);
        step();
        check("stream_end_count", 32'(count), 32'd0);

        // Full with simultaneous pop: pop happens, push refused
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h80 + 32'(4 * i));
            step();
        end
        check("full2_count", 32'(count), 32'd4);
        drive(1'b1, 32'h90);
        dec_ready = 1'b1;
        step();
        check("fullpop_count", 32'(count), 32'd3);
        check("fullpop_stall", 32'(stall_f), 32'd0);
        check("fullpop_head",  dec_data.pc, 32'h84);
        dec_ready = 1'b0;
        step();
        check("refill_count", 32'(count), 32'd4);
        drive(1'b0, 32'h0);
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("wrap_order", dec_data.pc, 32'h84 + 32'(4 * i));
            step();
        end
        check("wrap_empty", 32'(dec_valid), 32'd0);

        // Flush discards contents and the same-cycle packet
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20 + 32'(4 * i));
            step();
        end
        check("preflush_count", 32'(count), 32'd3);
        drive(1'b1, 32'h2C);
        dec_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(dec_valid), 32'd0);
        check("flush_stall", 32'(stall_f), 32'd0);
        drive(1'b1, 32'h100);
        dec_ready = 1'b0;
        step();
        check("target_pc",    dec_data.pc, 32'h100);
        check("target_p4",    dec_data.pc_plus_4, 32'h104);
        check("target_count", 32'(count), 32'd1);
        drive(1'b1, 32'h104);
        flush = 1'b1;
        step();
        check("flush2a_count", 32'(count), 32'd0);
        step();
        check("flush2b_count", 32'(count), 32'd0);
        check("flush2b_valid", 32'(dec_valid), 32'd0);
        flush = 1'b0;

        // Asynchronous reset between edges
        drive(1'b1, 32'h200);
        step();
        drive(1'b1, 32'h204);
        step();
        check("prerst_count", 32'(count), 32'd2);
        drive(1'b1, 32'h300);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(dec_valid), 32'd0);
        check("arst_stall", 32'(stall_f), 32'd0);
        check("arst_instr", dec_data.instr, 32'h13);
        rst = 1'b0;
        step();
        check("postrst_count", 32'(count), 32'd1);
        check("postrst_pc",    dec_data.pc, 32'h300);
        drive(1'b0, 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
